mcu_cmd_listener: RTL and testbench
===================================

# mcu_cmd_listener

Parametrised command/event dispatcher between the UART receiver, the waveform capture engines and the MCU communication unit. It frames host commands (start code + control byte), classifies the control byte against a configurable class table, and latches capture-complete events so none are lost while a transaction is in progress. Each accepted command or event produces a one-cycle flag and then holds until the communication unit reports completion, or until a watchdog timeout expires.

## Interface
- DW, 8: width of rx_data and ctrl_code.
- START_CODE, 8'h68: frame start byte.
- N_CLS, 6: number of command classes.
- CLS_LO, packed N_CLS×DW, {8'h42,8'h41,8'h31,8'h21,8'h11,8'h01}: per-class lower code bound. Class k occupies bits [k*DW +: DW].
- CLS_HI, packed N_CLS×DW, {8'h42,8'h41,8'h32,8'h22,8'h16,8'h06}: per-class upper code bound (inclusive).
- N_EVT, 2: number of save-complete event inputs. Bit 0 = power-frequency, bit 1 = travelling-wave.
- SRAM_DIR_MASK, N_EVT bits, 2'b10: events that drive sram_io_dir_ctrl.
- TIMEOUT, 50000: watchdog limit in clk cycles for WAIT_CODE and WAIT_DONE. 0 disables the watchdog.
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- rx_ok  in  1  UART byte-valid level. rx_data must be stable while it is high.
- rx_data  in  DW  received byte.
- evt_in  in  N_EVT  save-complete levels; each rising edge is one event.
- com_done_ok  in  1  transaction-complete level from the communication unit.
- ctrl_code  out  DW  accepted control byte. Held during WAIT_DONE; 0 otherwise.
- cmd_flag  out  N_CLS  one-hot, one-cycle class flag.
- evt_flag  out  N_EVT  one-hot, one-cycle event flag.
- sram_io_dir_ctrl  out  1  SRAM I/O direction; 1 while a masked event is being serviced.
- busy  out  1  high in every state except IDLE.
- err_badcode  out  1  one-cycle pulse: control byte matched no class.
- err_timeout  out  1  one-cycle pulse: watchdog expired.

## Operation
- rx_ok and each evt_in bit pass through a 2-FF synchroniser. Both stages reset to 1 so that no edge is seen after reset. rise = s1 & ~s2.
- Event pending register evt_pend[N_EVT-1:0]:
  - A rise sets its bit in any state, including IDLE.
  - The bit is cleared only when that event is dispatched.
  - Set and clear of the same bit in the same cycle: set wins, so the later event stays pending.
- Class match: class k matches when CLS_LO[k] <= code <= CLS_HI[k], unsigned compare. If several classes match, the lowest k wins.
- FSM states: IDLE, WAIT_CODE, DECODE, WAIT_DONE.
- IDLE (ctrl_code=0, sram_io_dir_ctrl=0). Priority order:
  1. rx_ok rise with rx_data==START_CODE -> WAIT_CODE.
  2. Any evt_pend bit set -> WAIT_DONE. The lowest pending index i is dispatched: evt_flag[i]=1 for one cycle, evt_pend[i] is cleared, and sram_io_dir_ctrl=SRAM_DIR_MASK[i].
  3. Otherwise stay in IDLE. An rx_ok rise with any other byte is ignored.
- WAIT_CODE:
  - rx_ok rise -> DECODE, with rx_data registered into code_r.
  - Watchdog expiry -> IDLE with err_timeout pulse.
- DECODE (one cycle):
  - Class k matched -> WAIT_DONE with cmd_flag[k]=1 and ctrl_code=code_r.
  - No class matched -> IDLE with err_badcode pulse.
- WAIT_DONE:
  - All flags are 0.
  - com_done_ok=1 -> IDLE. ctrl_code and sram_io_dir_ctrl are cleared on that edge.
  - Watchdog expiry -> IDLE with err_timeout pulse and the same clearing.
- Watchdog counter:
  - Cleared on every state entry; counts once per cycle in WAIT_CODE and WAIT_DONE.
  - Expiry occurs when count reaches TIMEOUT-1.
  - Width is $clog2(TIMEOUT+1).
- Events that arrive during a command are serviced after it, in index order. Each edge is retained until serviced.

## Timing
- Reset values: state=IDLE, evt_pend=0, code_r=0, counter=0, ctrl_code=0, and cmd_flag, evt_flag, sram_io_dir_ctrl, busy, err_badcode and err_timeout all 0.
- Reset is asynchronous and may be applied mid-transaction. All pending events are discarded.
- Synchroniser latency: rise is visible 2 clk after the input goes high.
- Command path, with the control byte's rise at cycle t:
  - DECODE at t+1.
  - cmd_flag and ctrl_code valid from t+2.
  - cmd_flag lasts exactly 1 cycle.
- Event path: an event seen in IDLE produces evt_flag on the next cycle.
- com_done_ok is honoured from the first WAIT_DONE cycle. If it is already high there, the block returns to IDLE after 1 cycle.
- Minimum gap between back-to-back dispatches is 2 cycles (WAIT_DONE then IDLE).
- busy rises on the edge that leaves IDLE and falls on the edge that enters IDLE.

## Test plan
- Bytes 0x68 then 0x03, each with an rx_ok pulse of 4 clk; com_done_ok after 10 clk -> cmd_flag=6'b000001 for one cycle, ctrl_code=0x03 held until done, then 0.
- Bytes 0x68 then 0x50 -> err_badcode pulse, no cmd_flag, busy falls; a following 0x68/0x41 is accepted with cmd_flag[4].
- evt_in[1] and evt_in[0] rise in the same cycle while a command is in WAIT_DONE -> after done, evt_flag=01 and then, after a second done, evt_flag=10 with sram_io_dir_ctrl=1.
- TIMEOUT=20; 0x68 sent with no second byte -> err_timeout exactly 20 cycles after WAIT_CODE entry, return to IDLE. Same check for WAIT_DONE with com_done_ok held low.
- rst asserted low mid-WAIT_DONE with evt_pend=11 -> all outputs 0 immediately; after release, no flags are produced while evt_in stays high.
- In IDLE, start-code rise and evt_in[0] rise in the same cycle -> command path wins; the event is serviced after com_done_ok.

Source files
------------

// File: rtl/mcu_cmd_listener.sv
// Command/event dispatcher: frames host commands (start code + control byte),
// classifies the control byte and arbitrates latched capture-complete events.
module mcu_cmd_listener #(
   parameter int                  DW            = 8,
   parameter logic [DW-1:0]       START_CODE    = 8'h68,
   parameter int                  N_CLS         = 6,
   parameter logic [N_CLS*DW-1:0] CLS_LO        = {8'h42, 8'h41, 8'h31, 8'h21, 8'h11, 8'h01},
   parameter logic [N_CLS*DW-1:0] CLS_HI        = {8'h42, 8'h41, 8'h32, 8'h22, 8'h16, 8'h06},
   parameter int                  N_EVT         = 2,
   parameter logic [N_EVT-1:0]    SRAM_DIR_MASK = 2'b10,
   parameter int                  TIMEOUT       = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_ok,
   input  logic [DW-1:0]    rx_data,
   input  logic [N_EVT-1:0] evt_in,
   input  logic             com_done_ok,
   output logic [DW-1:0]    ctrl_code,
   output logic [N_CLS-1:0] cmd_flag,
   output logic [N_EVT-1:0] evt_flag,
   output logic             sram_io_dir_ctrl,
   output logic             busy,
   output logic             err_badcode,
   output logic             err_timeout
);

   localparam int             CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int             WD_LIM_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0]  WD_LIM   = WD_LIM_I[CW-1:0];

   typedef enum logic [1:0] {IDLE, WAIT_CODE, DECODE, WAIT_DONE} state_t;

   state_t             state;
   logic               rx_s1, rx_s2;
   logic [N_EVT-1:0]   evt_s1, evt_s2;
   logic [N_EVT-1:0]   evt_pend;
   logic [DW-1:0]      code_r;
   logic [CW-1:0]      wd_cnt;

   logic               rx_rise, start_hit, evt_any, sel_dir, cls_hit, wd_exp;
   logic [N_EVT-1:0]   evt_rise, pend_eff, evt_sel, evt_clr, pend_nxt;
   logic [N_CLS-1:0]   cls_sel;

   // Synchroniser stages reset high so a level already present at reset release is not an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_s1  <= 1'b1;
         rx_s2  <= 1'b1;
         evt_s1 <= '1;
         evt_s2 <= '1;
      end else begin
         rx_s1  <= rx_ok;
         rx_s2  <= rx_s1;
         evt_s1 <= evt_in;
         evt_s2 <= evt_s1;
      end
   end

   always_comb begin
      rx_rise   = rx_s1 & ~rx_s2;
      evt_rise  = evt_s1 & ~evt_s2;
      start_hit = rx_rise && (rx_data == START_CODE);
      pend_eff  = evt_pend | evt_rise;
      evt_sel   = '0;
      sel_dir   = 1'b0;
      for (int i = N_EVT - 1; i >= 0; i--) begin
         if (pend_eff[i]) begin
            evt_sel    = '0;
            evt_sel[i] = 1'b1;
            sel_dir    = SRAM_DIR_MASK[i];
         end
      end
      evt_any = |pend_eff;
      evt_clr = (state == IDLE && !start_hit) ? evt_sel : '0;
      // A fresh edge landing on an already-pending bit survives its dispatch.
      pend_nxt = '0;
      for (int i = 0; i < N_EVT; i++)
         pend_nxt[i] = evt_clr[i] ? (evt_pend[i] & evt_rise[i]) : pend_eff[i];
      cls_sel = '0;
      for (int k = N_CLS - 1; k >= 0; k--) begin
         if (code_r >= CLS_LO[k*DW +: DW] && code_r <= CLS_HI[k*DW +: DW]) begin
            cls_sel    = '0;
            cls_sel[k] = 1'b1;
         end
      end
      cls_hit = |cls_sel;
      wd_exp  = (TIMEOUT != 0) && (wd_cnt == WD_LIM);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         evt_pend         <= '0;
         code_r           <= '0;
         wd_cnt           <= '0;
         ctrl_code        <= '0;
         cmd_flag         <= '0;
         evt_flag         <= '0;
         sram_io_dir_ctrl <= 1'b0;
         busy             <= 1'b0;
         err_badcode      <= 1'b0;
         err_timeout      <= 1'b0;
      end else begin
         cmd_flag    <= '0;
         evt_flag    <= '0;
         err_badcode <= 1'b0;
         err_timeout <= 1'b0;
         evt_pend    <= pend_nxt;
         case (state)
            IDLE: begin
               wd_cnt <= '0;
               if (start_hit) begin
                  state <= WAIT_CODE;
                  busy  <= 1'b1;
               end else if (evt_any) begin
                  state            <= WAIT_DONE;
                  busy             <= 1'b1;
                  evt_flag         <= evt_sel;
                  sram_io_dir_ctrl <= sel_dir;
               end
            end
            WAIT_CODE: begin
               if (rx_rise) begin
                  code_r <= rx_data;
                  state  <= DECODE;
                  wd_cnt <= '0;
               end else if (wd_exp) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  err_timeout <= 1'b1;
                  wd_cnt      <= '0;
               end else if (TIMEOUT != 0) begin
                  wd_cnt <= wd_cnt + CW'(1);
               end
            end
            DECODE: begin
               wd_cnt <= '0;
               if (cls_hit) begin
                  state     <= WAIT_DONE;
                  cmd_flag  <= cls_sel;
                  ctrl_code <= code_r;
               end else begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  err_badcode <= 1'b1;
               end
            end
            WAIT_DONE: begin
               if (com_done_ok || wd_exp) begin
                  state            <= IDLE;
                  busy             <= 1'b0;
                  ctrl_code        <= '0;
                  sram_io_dir_ctrl <= 1'b0;
                  err_timeout      <= !com_done_ok;
                  wd_cnt           <= '0;
               end else if (TIMEOUT != 0) begin
                  wd_cnt <= wd_cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mcu_cmd_listener.sv
// Bench for mcu_cmd_listener: edge-history/age based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mcu_cmd_listener;

   localparam int TO = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx_ok = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [1:0] evt_in = 2'b00;
   logic       com_done_ok = 1'b0;
   logic [7:0] ctrl_code;
   logic [5:0] cmd_flag;
   logic [1:0] evt_flag;
   logic       sram_io_dir_ctrl, busy, err_badcode, err_timeout;

   mcu_cmd_listener #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .rx_ok(rx_ok), .rx_data(rx_data), .evt_in(evt_in),
      .com_done_ok(com_done_ok), .ctrl_code(ctrl_code), .cmd_flag(cmd_flag),
      .evt_flag(evt_flag), .sram_io_dir_ctrl(sram_io_dir_ctrl), .busy(busy),
      .err_badcode(err_badcode), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   byte unsigned cls_lo[6] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h41, 8'h42};
   byte unsigned cls_hi[6] = '{8'h06, 8'h16, 8'h22, 8'h32, 8'h41, 8'h42};
   logic [1:0]   dir_mask  = 2'b10;

   function automatic int classify(input logic [7:0] c);
      for (int k = 0; k < 6; k++)
         if (c >= cls_lo[k] && c <= cls_hi[k]) return k;
      return -1;
   endfunction

   localparam int M_IDLE = 0, M_WCODE = 1, M_DEC = 2, M_WDONE = 3;
   int         m_mode = M_IDLE;
   int         m_cyc = 0, m_entry = 0;
   int         m_pend[2] = '{0, 0};
   logic       m_rx_1ago = 1'b1, m_rx_2ago = 1'b1;
   logic [1:0] m_ev_1ago = 2'b11, m_ev_2ago = 2'b11;
   logic [7:0] m_code = 8'h00;
   logic [5:0] e_cmd = '0;
   logic [1:0] e_evt = '0;
   logic [7:0] e_code = '0;
   logic       e_sram = 1'b0, e_busy = 1'b0, e_bad = 1'b0, e_to = 1'b0;

   task automatic m_enter(input int md);
      m_mode  = md;
      m_entry = m_cyc;
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_mode = M_IDLE; m_pend = '{0, 0}; m_code = 8'h00;
         m_rx_1ago = 1'b1; m_rx_2ago = 1'b1; m_ev_1ago = 2'b11; m_ev_2ago = 2'b11;
         e_cmd = '0; e_evt = '0; e_code = '0; e_sram = 0; e_busy = 0; e_bad = 0; e_to = 0;
      end else begin
         logic       rx_edge;
         logic [1:0] ev_edge;
         logic [1:0] taken;
         int         age, k;
         bit         found;
         m_cyc++;
         rx_edge   = m_rx_1ago & ~m_rx_2ago;
         ev_edge   = m_ev_1ago & ~m_ev_2ago;
         m_rx_2ago = m_rx_1ago; m_rx_1ago = rx_ok;
         m_ev_2ago = m_ev_1ago; m_ev_1ago = evt_in;
         e_cmd = '0; e_evt = '0; e_bad = 0; e_to = 0;
         taken = '0;
         age   = m_cyc - m_entry;
         case (m_mode)
            M_IDLE: begin
               if (rx_edge && rx_data == 8'h68) m_enter(M_WCODE);
               else begin
                  found = 0;
                  for (int i = 0; i < 2; i++)
                     if (!found && (m_pend[i] > 0 || ev_edge[i])) begin
                        found = 1; taken[i] = 1'b1;
                        e_evt[i] = 1'b1; e_sram = dir_mask[i];
                        m_enter(M_WDONE);
                     end
               end
            end
            M_WCODE: begin
               if (rx_edge) begin m_code = rx_data; m_enter(M_DEC); end
               else if (age == TO) begin e_to = 1; m_enter(M_IDLE); end
            end
            M_DEC: begin
               k = classify(m_code);
               if (k >= 0) begin e_cmd[k] = 1'b1; e_code = m_code; m_enter(M_WDONE); end
               else begin e_bad = 1; m_enter(M_IDLE); end
            end
            default: begin
               if (com_done_ok || age == TO) begin
                  e_to = !com_done_ok; e_code = '0; e_sram = 0; m_enter(M_IDLE);
               end
            end
         endcase
         for (int i = 0; i < 2; i++) m_pend[i] += int'(ev_edge[i]) - int'(taken[i]);
         e_busy = (m_mode != M_IDLE);
      end
   end

   // ---------------- per-cycle compare and event log ----------------
   bit         cmp_en = 0;
   int         tcyc = 0;
   logic [5:0] cap_cmd = '0;
   logic [7:0] cap_code = '0;
   int         cmd_cyc = 0, n_cmd_cyc = 0, n_bad = 0, n_to = 0, to_cyc = 0, busy_cyc = 0;
   logic       prev_busy = 1'b0;
   logic [1:0] q_evt[$];
   logic       q_sram[$];

   always begin
      @(posedge clk);
      #3;
      tcyc++;
      if (cmp_en) begin
         chk("cmd_flag", 32'(cmd_flag), 32'(e_cmd));
         chk("evt_flag", 32'(evt_flag), 32'(e_evt));
         chk("ctrl_code", 32'(ctrl_code), 32'(e_code));
         chk("sram_io_dir_ctrl", 32'(sram_io_dir_ctrl), 32'(e_sram));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("err_badcode", 32'(err_badcode), 32'(e_bad));
         chk("err_timeout", 32'(err_timeout), 32'(e_to));
      end
      if (cmd_flag != 0) begin cap_cmd = cmd_flag; cap_code = ctrl_code; cmd_cyc = tcyc; n_cmd_cyc++; end
      if (evt_flag != 0) begin q_evt.push_back(evt_flag); q_sram.push_back(sram_io_dir_ctrl); end
      if (err_badcode) n_bad++;
      if (err_timeout) begin n_to++; to_cyc = tcyc; end
      if (busy && !prev_busy) busy_cyc = tcyc;
      prev_busy = busy;
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b; rx_ok = 1'b1;
      idle(4);
      rx_ok = 1'b0;
      idle(2);
   endtask

   task automatic done_pulse();
      @(negedge clk);
      com_done_ok = 1'b1;
      @(negedge clk);
      com_done_ok = 1'b0;
   endtask

   initial begin
      idle(3);
      chk("reset ctrl_code", 32'(ctrl_code), 0);
      chk("reset flags", {cmd_flag, evt_flag, sram_io_dir_ctrl, busy, err_badcode, err_timeout}, 0);
      rst = 1'b1;
      cmp_en = 1;
      idle(3);

      // basic command 0x68/0x03
      send_byte(8'h68);
      send_byte(8'h03);
      idle(7);
      chk("t1 cmd_flag", 32'(cap_cmd), 32'h01);
      chk("t1 ctrl_code at flag", 32'(cap_code), 32'h03);
      chk("t1 ctrl_code held", 32'(ctrl_code), 32'h03);
      chk("t1 cmd one cycle", n_cmd_cyc, 1);
      done_pulse();
      idle(3);
      chk("t1 ctrl_code cleared", 32'(ctrl_code), 0);
      chk("t1 busy low", 32'(busy), 0);

      // bad code then a valid one
      send_byte(8'h68);
      send_byte(8'h50);
      idle(3);
      chk("t2 badcode pulses", n_bad, 1);
      chk("t2 no cmd", n_cmd_cyc, 1);
      chk("t2 busy low", 32'(busy), 0);
      send_byte(8'h68);
      send_byte(8'h41);
      chk("t2 cmd_flag 0x41", 32'(cap_cmd), 32'h10);
      done_pulse();
      idle(3);

      // two events arriving together during a command
      q_evt.delete(); q_sram.delete();
      send_byte(8'h68);
      send_byte(8'h21);
      @(negedge clk); evt_in = 2'b11;
      idle(3);
      done_pulse();
      idle(4);
      done_pulse();
      idle(4);
      done_pulse();
      idle(3);
      evt_in = 2'b00;
      idle(3);
      chk("t3 event count", q_evt.size(), 2);
      if (q_evt.size() == 2) begin
         chk("t3 first evt_flag", 32'(q_evt[0]), 32'h1);
         chk("t3 first sram dir", 32'(q_sram[0]), 0);
         chk("t3 second evt_flag", 32'(q_evt[1]), 32'h2);
         chk("t3 second sram dir", 32'(q_sram[1]), 1);
      end

      // watchdog in WAIT_CODE then WAIT_DONE
      send_byte(8'h68);
      idle(30);
      chk("t4 timeout count", n_to, 1);
      chk("t4 wait_code timeout latency", to_cyc - busy_cyc, TO);
      send_byte(8'h68);
      send_byte(8'h01);
      idle(30);
      chk("t4 timeout count 2", n_to, 2);
      chk("t4 wait_done timeout latency", to_cyc - cmd_cyc, TO);
      chk("t4 ctrl_code cleared", 32'(ctrl_code), 0);

      // reset mid-WAIT_DONE with both events pending
      q_evt.delete(); q_sram.delete();
      send_byte(8'h68);
      send_byte(8'h22);
      @(negedge clk); evt_in = 2'b11;
      idle(4);
      #2 rst = 1'b0;
      #1;
      chk("t5 async ctrl_code", 32'(ctrl_code), 0);
      chk("t5 async busy", 32'(busy), 0);
      chk("t5 async sram", 32'(sram_io_dir_ctrl), 0);
      idle(2);
      rst = 1'b1;
      idle(10);
      chk("t5 no events after reset", q_evt.size(), 0);
      chk("t5 busy idle", 32'(busy), 0);
      evt_in = 2'b00;
      idle(3);

      // start code and event edge together: command first
      @(negedge clk);
      rx_data = 8'h68; rx_ok = 1'b1; evt_in = 2'b01;
      idle(4);
      rx_ok = 1'b0;
      idle(2);
      send_byte(8'h31);
      chk("t6 cmd_flag class3", 32'(cap_cmd), 32'h08);
      chk("t6 event deferred", q_evt.size(), 0);
      idle(2);
      done_pulse();
      idle(3);
      chk("t6 event serviced", q_evt.size(), 1);
      if (q_evt.size() == 1) chk("t6 evt_flag", 32'(q_evt[0]), 32'h1);
      done_pulse();
      evt_in = 2'b00;
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
